arm_alu: RTL and testbench

//  32-bit ARM-style data-processing ALU for the SimpleARM datapath execute stage.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/arm_alu_if.sv | 28 ++
 rtl/alu_adder.sv | 29 ++
 rtl/arm_alu.sv | 107 ++++++++++
 tb/tb_arm_alu.sv | 132 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the arm_alu data-processing ALU.
//   alu_op_e      : 4-bit ARM data-processing opcode encoding
//   FLAG_N..V     : bit positions of the NZCV flags in the flags vector
//   is_test_op()  : TST/TEQ/CMP/CMN, which compute flags but do not write back
//   is_arith_op() : opcodes whose result and C/V come from the adder
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_PAS = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_test_op(input alu_op_e op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

    function automatic logic is_arith_op(input alu_op_e op);
        return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC,
                          OP_SBC, OP_RSC, OP_CMP, OP_CMN};
    endfunction

endpackage

// File: rtl/arm_alu_if.sv
// -----------------------------------------------------------------------------
// arm_alu_if
// Operand/result bundle between the execute-stage control and the ALU.
//   en, a, b, carry, opcode : driven by the master (control/datapath)
//   out, flags, wr_result   : driven by the slave (arm_alu), registered
// -----------------------------------------------------------------------------
interface arm_alu_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    logic             wr_result;

    modport master (
        output en, a, b, carry, opcode,
        input  out, flags, wr_result
    );

    modport slave (
        input  en, a, b, carry, opcode,
        output out, flags, wr_result
    );
endinterface

// File: rtl/alu_adder.sv
// -----------------------------------------------------------------------------
// alu_adder
// Purely combinational x + y + cin with carry-out and signed overflow.
//   i_x, i_y : operands as presented to the adder (already inverted if needed)
//   i_cin    : carry-in
//   o_sum    : sum modulo 2^WIDTH
//   o_cout   : carry-out (for subtraction: 1 = no borrow)
//   o_ovf    : signed overflow of the addition actually performed
// -----------------------------------------------------------------------------
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, i_x} + {1'b0, i_y} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum  = w_full[WIDTH-1:0];
    assign o_cout = w_full[WIDTH];
    // Overflow uses the adder's own operand signs, so inverted subtrahends
    // are handled without a separate subtract rule.
    assign o_ovf  = (i_x[WIDTH-1] == i_y[WIDTH-1]) &&
                    (o_sum[WIDTH-1] != i_x[WIDTH-1]);
endmodule

// File: rtl/arm_alu.sv
// -----------------------------------------------------------------------------
// arm_alu
// 32-bit ARM data-processing ALU with registered result and NZCV flags.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears out/flags/wr_result, beats en
//   bus   : arm_alu_if.slave -- en/a/b/carry/opcode in, out/flags/wr_result out
// Results appear one cycle after the operands when en=1; en=0 holds outputs.
// -----------------------------------------------------------------------------
module arm_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    arm_alu_if.slave    bus
);
    alu_op_e          w_op;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_flags;
    logic             w_arith;

    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_flags;
    logic             r_wr_result;

    assign w_op    = alu_op_e'(bus.opcode);
    assign w_arith = is_arith_op(w_op);

    // Operand select/invert: reverse ops swap a and b, subtracts invert the
    // subtrahend and take cin=1 (or the C flag for the with-carry forms).
    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // through this block can leave a value unassigned and infer a latch.
        w_x   = bus.a;
        w_y   = bus.b;
        w_cin = 1'b0;
        unique case (w_op)
            OP_SUB, OP_CMP: begin w_y = ~bus.b; w_cin = 1'b1; end
            OP_RSB:         begin w_x = bus.b; w_y = ~bus.a; w_cin = 1'b1; end
            OP_ADC:         begin w_cin = bus.carry; end
            OP_SBC:         begin w_y = ~bus.b; w_cin = bus.carry; end
            OP_RSC:         begin w_x = bus.b; w_y = ~bus.a; w_cin = bus.carry; end
            default:        ;
        endcase
    end

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    // Logic unit; arithmetic opcodes fall to the default and are replaced
    // by the adder sum below.
    always_comb begin
        w_logic = '0;
        unique case (w_op)
            OP_AND, OP_TST: w_logic = bus.a & bus.b;
            OP_EOR, OP_TEQ: w_logic = bus.a ^ bus.b;
            OP_ORR:         w_logic = bus.a | bus.b;
            OP_PAS:         w_logic = bus.b;
            OP_BIC:         w_logic = bus.a & ~bus.b;
            OP_MVN:         w_logic = ~bus.b;
            default:        w_logic = '0;
        endcase
    end

    assign w_result = w_arith ? w_sum : w_logic;

    // Logical ops pass the incoming C through and clear V.
    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = w_result[WIDTH-1];
        w_flags[FLAG_Z] = (w_result == '0);
        w_flags[FLAG_C] = w_arith ? w_cout : bus.carry;
        w_flags[FLAG_V] = w_arith & w_ovf;
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            r_out       <= '0;
            r_flags     <= '0;
            r_wr_result <= 1'b0;
        end else if (bus.en) begin
            r_out       <= w_result;
            r_flags     <= w_flags;
            r_wr_result <= ~is_test_op(w_op);
        end
    end

    assign bus.out       = r_out;
    assign bus.flags     = r_flags;
    assign bus.wr_result = r_wr_result;
endmodule

// File: tb/tb_arm_alu.sv
// -----------------------------------------------------------------------------
// tb_arm_alu
// Directed, table-driven bench for arm_alu: one vector per opcode class and
// flag corner, plus hand sequences for en-hold and reset-vs-en priority.
// -----------------------------------------------------------------------------
module tb_arm_alu;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] exp_out;
        logic [3:0]  exp_flags;
        logic        exp_wr;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    vec_t vq[$];

    arm_alu_if #(.WIDTH(32)) bus ();

    arm_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [31:0] eo, input logic [3:0] ef, input logic ew);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.c = c;
        v.exp_out = eo; v.exp_flags = ef; v.exp_wr = ew;
        vq.push_back(v);
    endtask

    task automatic drive(input logic en, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        bus.en = en; bus.opcode = op; bus.a = a; bus.b = b; bus.carry = c;
    endtask

    task automatic check_outs(input string name, input logic [31:0] eo,
                              input logic [3:0] ef, input logic ew);
        check({name, ".out"},   bus.out, eo);
        check({name, ".flags"}, {28'd0, bus.flags}, {28'd0, ef});
        check({name, ".wr"},    {31'd0, bus.wr_result}, {31'd0, ew});
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.en = 1'b0; bus.opcode = 4'h0; bus.a = '0; bus.b = '0; bus.carry = 1'b0;

        //    name         op      a             b             c     out           NZCV     wr
        add("and",        OP_AND, 32'h1F,       32'h0A,       1'b0, 32'h0A,       4'b0000, 1'b1);
        add("eor_z",      OP_EOR, 32'h1F,       32'h1F,       1'b0, 32'h0,        4'b0100, 1'b1);
        add("eor_zc",     OP_EOR, 32'h1F,       32'h1F,       1'b1, 32'h0,        4'b0110, 1'b1);
        add("sub_pos",    OP_SUB, 32'd12,       32'd7,        1'b0, 32'd5,        4'b0010, 1'b1);
        add("sub_neg",    OP_SUB, 32'd7,        32'd12,       1'b0, 32'hFFFFFFFB, 4'b1000, 1'b1);
        add("sub_zero",   OP_SUB, 32'd7,        32'd7,        1'b0, 32'h0,        4'b0110, 1'b1);
        add("sub_ovf",    OP_SUB, 32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 4'b0011, 1'b1);
        add("add_ovf",    OP_ADD, 32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 4'b1001, 1'b1);
        add("add_negovf", OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 32'h0,        4'b0111, 1'b1);
        add("adc_wrap",   OP_ADC, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        4'b0110, 1'b1);
        add("rsb",        OP_RSB, 32'd3,        32'd10,       1'b0, 32'd7,        4'b0010, 1'b1);
        add("sbc_c0",     OP_SBC, 32'd10,       32'd3,        1'b0, 32'd6,        4'b0010, 1'b1);
        add("rsc_c1",     OP_RSC, 32'd10,       32'd3,        1'b1, 32'hFFFFFFF9, 4'b1000, 1'b1);
        add("cmn",        OP_CMN, 32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,        4'b0110, 1'b0);
        add("tst",        OP_TST, 32'hF0,       32'h0F,       1'b1, 32'h0,        4'b0110, 1'b0);
        add("teq",        OP_TEQ, 32'h80000000, 32'h0,        1'b0, 32'h80000000, 4'b1000, 1'b0);
        add("orr",        OP_ORR, 32'hF0,       32'h0F,       1'b1, 32'hFF,       4'b0010, 1'b1);
        add("pas",        OP_PAS, 32'h123,      32'h80000001, 1'b0, 32'h80000001, 4'b1000, 1'b1);
        add("bic",        OP_BIC, 32'hFF,       32'h0F,       1'b0, 32'hF0,       4'b0000, 1'b1);
        add("mvn",        OP_MVN, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFF, 4'b1000, 1'b1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1 check_outs("reset", 32'h0, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Table: outputs must reflect the operands one edge after they are applied.
        foreach (vq[i]) begin
            drive(1'b1, vq[i].op, vq[i].a, vq[i].b, vq[i].c);
            @(posedge clk);
            #1 check_outs(vq[i].name, vq[i].exp_out, vq[i].exp_flags, vq[i].exp_wr);
        end

        // CMP then hold with en=0 while the inputs change.
        drive(1'b1, OP_CMP, 32'd5, 32'd5, 1'b0);
        @(posedge clk);
        #1 check_outs("cmp", 32'h0, 4'b0110, 1'b0);
        drive(1'b0, OP_ADD, 32'd1, 32'd2, 1'b1);
        repeat (2) @(posedge clk);
        #1 check_outs("hold", 32'h0, 4'b0110, 1'b0);

        // Reset asserted together with en: reset wins.
        drive(1'b1, OP_ADD, 32'd3, 32'd4, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 check_outs("rst_vs_en", 32'h0, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check_outs("after_rst", 32'd7, 4'b0000, 1'b1);

        @(negedge clk);
        bus.en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
